// File: rtl/mdu_hilo.sv
// Multiply/divide unit owning the HI/LO register pair, with MADD/MSUB accumulate,
// direct mthi/mtlo writes and an abort path for pipeline flushes.
module mdu_hilo #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             we,
    input  logic             wsel,
    input  logic [WIDTH-1:0] wd,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {StIdle, StRun} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               accept, finish, wr_ok;
    logic [WIDTH-1:0]   hi_w, lo_w;

    logic [2*WIDTH-1:0] a_ext, b_ext, prod, result;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag, quot, rem;

    assign busy   = (state_q == StRun);
    assign accept = start && !busy && !abort;
    assign finish = busy && (cnt_q == '0) && !abort && !reset;
    assign done   = finish;
    assign wr_ok  = we && !busy;
    assign hi     = hi_q;
    assign lo     = lo_q;

    // Direct write is applied ahead of the latch so MADD/MSUB see post-write HI/LO.
    assign hi_w = (wr_ok && wsel)  ? wd : hi_q;
    assign lo_w = (wr_ok && !wsel) ? wd : lo_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StRun;
                    cnt_d   = (op[2:1] == 2'b01) ? DIV_LOAD : MULT_LOAD;
                end
            end
            StRun: begin
                if (abort || cnt_q == '0) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // op[0] selects the signed variant for every operation class.
    always_comb begin
        a_ext = op_q[0] ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext = op_q[0] ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod  = a_ext * b_ext;

        a_neg = op_q[0] & a_q[WIDTH-1];
        b_neg = op_q[0] & b_q[WIDTH-1];
        a_mag = a_neg ? -a_q : a_q;
        b_mag = b_neg ? -b_q : b_q;
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
        quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem   = a_neg ? -r_mag : r_mag;
        if (b_q == '0) begin
            quot = '1;
            rem  = a_q;
        end

        case (op_q[2:1])
            2'b00:   result = prod;
            2'b01:   result = {rem, quot};
            2'b10:   result = acc_q + prod;
            default: result = acc_q - prod;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q  <= op;
                a_q   <= a;
                b_q   <= b;
                acc_q <= {hi_w, lo_w};
            end
            if (finish) begin
                {hi_q, lo_q} <= result;
            end else begin
                hi_q <= hi_w;
                lo_q <= lo_w;
            end
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: 32-bit instance with directed vectors, 8-bit
// single-cycle instance swept against a small reference model.
module tb_mdu_hilo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst32, start32, we32, wsel32, abort32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, wd32;
    logic        busy32, done32;
    logic [31:0] hi32, lo32;

    logic        rst8, start8, we8, wsel8, abort8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, wd8;
    logic        busy8, done8;
    logic [7:0]  hi8, lo8;

    mdu_hilo #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut32 (
        .clk(clk), .reset(rst32), .start(start32), .op(op32), .a(a32), .b(b32),
        .we(we32), .wsel(wsel32), .wd(wd32), .abort(abort32),
        .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
    );

    mdu_hilo #(.WIDTH(8), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut8 (
        .clk(clk), .reset(rst8), .start(start8), .op(op8), .a(a8), .b(b8),
        .we(we8), .wsel(wsel8), .wd(wd8), .abort(abort8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [63:0] q32[$];
    logic [15:0] q8[$];
    bit          pend32 = 0, pend8 = 0;
    logic [63:0] e32;
    logic [15:0] e8;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endfunction

    // Monitor: done seen at one negedge, HI/LO compared at the next.
    always @(negedge clk) begin
        if (pend32) begin
            chk("sb32_hilo", {hi32, lo32}, e32);
            pend32 = 0;
        end
        if (pend8) begin
            chk("sb8_hilo", {48'b0, hi8, lo8}, {48'b0, e8});
            pend8 = 0;
        end
        if (!rst32 && done32) begin
            if (q32.size() == 0) chk("sb32_unexpected_done", {63'b0, done32}, 64'd0);
            else begin
                e32    = q32.pop_front();
                pend32 = 1;
            end
        end
        if (!rst8 && done8) begin
            if (q8.size() == 0) chk("sb8_unexpected_done", {63'b0, done8}, 64'd0);
            else begin
                e8    = q8.pop_front();
                pend8 = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle32();
        int n = 0;
        while (busy32 && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk("timeout32", {63'b0, busy32}, 64'd0);
    endtask

    task automatic run32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] exp);
        op32    = o;
        a32     = x;
        b32     = y;
        start32 = 1'b1;
        q32.push_back(exp);
        step();
        start32 = 1'b0;
        we32    = 1'b0;
        wait_idle32();
    endtask

    function automatic logic [15:0] model8(input logic [2:0] o, input logic [7:0] x,
                                           input logic [7:0] y, input logic [15:0] acc);
        int sx, sy, qv, rv;
        longint p;
        logic [15:0] pr;
        sx = o[0] ? int'($signed(x)) : int'(x);
        sy = o[0] ? int'($signed(y)) : int'(y);
        p  = longint'(sx) * longint'(sy);
        pr = p[15:0];
        case (o)
            3'd0, 3'd1: return pr;
            3'd4, 3'd5: return acc + pr;
            3'd6, 3'd7: return acc - pr;
            default: begin
                if (y == 8'd0) return {x, 8'hFF};
                qv = sx / sy;
                rv = sx % sy;
                return {rv[7:0], qv[7:0]};
            end
        endcase
    endfunction

    initial begin
        logic [15:0] m8;
        logic [2:0]  o;
        logic [7:0]  x, y, wdv;
        logic        w, ws;

        {start32, we32, wsel32, abort32, op32, a32, b32, wd32} = '0;
        {start8, we8, wsel8, abort8, op8, a8, b8, wd8} = '0;
        rst32 = 1'b1;
        rst8  = 1'b1;
        step();
        step();
        rst32 = 1'b0;
        rst8  = 1'b0;
        chk("reset_hilo32", {hi32, lo32}, 64'd0);
        chk("reset_busy32", {63'b0, busy32}, 64'd0);
        chk("reset_done32", {63'b0, done32}, 64'd0);
        chk("reset_hilo8", {48'b0, hi8, lo8}, 64'd0);

        // MULT -3*7: busy t+1..t+5, done at t+5
        op32 = 3'd1; a32 = 32'hFFFF_FFFD; b32 = 32'd7; start32 = 1'b1;
        q32.push_back(64'hFFFFFFFF_FFFFFFEB);
        step();
        start32 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("t1_busy_c%0d", k), {63'b0, busy32}, 64'd1);
            chk($sformatf("t1_done_c%0d", k), {63'b0, done32}, {63'b0, k == 5});
            step();
        end
        chk("t1_busy_after", {63'b0, busy32}, 64'd0);
        chk("t1_hilo", {hi32, lo32}, 64'hFFFFFFFF_FFFFFFEB);

        // Division cases
        run32(3'd3, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        run32(3'd2, 32'd7, 32'd0, 64'h00000007_FFFFFFFF);
        run32(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000);
        run32(3'd3, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD);
        run32(3'd2, 32'd100, 32'd7, 64'h00000002_0000000E);

        // Direct writes and accumulate
        we32 = 1'b1; wsel32 = 1'b1; wd32 = 32'd1;
        step();
        wsel32 = 1'b0; wd32 = 32'hFFFF_FFFF;
        step();
        we32 = 1'b0;
        chk("t3_mthi_mtlo", {hi32, lo32}, 64'h00000001_FFFFFFFF);
        run32(3'd4, 32'd1, 32'd1, 64'h00000002_00000000);
        run32(3'd0, 32'd0, 32'd0, 64'h0);
        run32(3'd7, 32'd2, 32'd3, 64'hFFFFFFFF_FFFFFFFA);
        we32 = 1'b1; wsel32 = 1'b0; wd32 = 32'd5;
        run32(3'd4, 32'd2, 32'd3, 64'hFFFFFFFF_0000000B);
        run32(3'd5, 32'hFFFF_FFFF, 32'd2, 64'hFFFFFFFF_00000009);
        run32(3'd6, 32'hFFFF_FFFF, 32'd2, 64'hFFFFFFFD_0000000B);

        // Abort: second start ignored, no done, HI/LO held
        op32 = 3'd0; a32 = 32'd5; b32 = 32'd5; start32 = 1'b1;
        step();
        start32 = 1'b0;
        step();
        op32 = 3'd1; a32 = 32'd9; b32 = 32'd9; start32 = 1'b1;
        step();
        start32 = 1'b0;
        chk("t4_busy_pre_abort", {63'b0, busy32}, 64'd1);
        abort32 = 1'b1;
        step();
        abort32 = 1'b0;
        chk("t4_busy_after_abort", {63'b0, busy32}, 64'd0);
        for (int k = 0; k < 8; k++) step();
        chk("t4_hilo_held", {hi32, lo32}, 64'hFFFFFFFD_0000000B);

        // Reset mid-operation
        op32 = 3'd1; a32 = 32'd3; b32 = 32'd4; start32 = 1'b1;
        step();
        start32 = 1'b0;
        step();
        rst32 = 1'b1;
        step();
        rst32 = 1'b0;
        chk("t5_hilo_reset", {hi32, lo32}, 64'd0);
        chk("t5_busy_reset", {63'b0, busy32}, 64'd0);
        run32(3'd0, 32'd6, 32'd7, 64'h00000000_0000002A);

        // 8-bit single-cycle sweep against the model
        m8 = 16'd0;
        for (int i = 0; i < 24; i++) begin
            o   = 3'($urandom_range(0, 7));
            x   = 8'($urandom);
            y   = 8'($urandom);
            if (i % 4 == 1) y = 8'd0;
            if (i == 2) begin
                o = 3'd3; x = 8'h80; y = 8'hFF;
            end
            w   = (i % 3 == 0);
            ws  = 1'($urandom_range(0, 1));
            wdv = 8'($urandom);
            if (w) begin
                if (ws) m8[15:8] = wdv;
                else m8[7:0] = wdv;
            end
            m8 = model8(o, x, y, m8);
            op8 = o; a8 = x; b8 = y; we8 = w; wsel8 = ws; wd8 = wdv; start8 = 1'b1;
            q8.push_back(m8);
            step();
            start8 = 1'b0;
            we8    = 1'b1;
            wsel8  = 1'($urandom_range(0, 1));
            wd8    = 8'($urandom);
            chk($sformatf("t6_busy_%0d", i), {63'b0, busy8}, 64'd1);
            chk($sformatf("t6_done_%0d", i), {63'b0, done8}, 64'd1);
            step();
            we8 = 1'b0;
            chk($sformatf("t6_idle_%0d", i), {63'b0, busy8}, 64'd0);
            chk($sformatf("t6_done_clear_%0d", i), {63'b0, done8}, 64'd0);
            chk($sformatf("t6_hilo_%0d", i), {48'b0, hi8, lo8}, {48'b0, m8});
        end

        step();
        step();
        chk("sb32_drain", 64'(q32.size()), 64'd0);
        chk("sb8_drain", 64'(q8.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
